// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, waits RD_WAIT cycles for the async imem read,
// then presents the word to decode with valid/ready; supports redirect and sticky halt.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      instr_out,
  output logic [31:0]      instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             halt,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [3:0]  WAIT_INIT = 4'(RD_WAIT - 1);
  localparam logic [31:0] STEP      = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_VALID = 2'b01,
    S_HALT  = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [3:0]       wait_q, wait_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      ipc_q, ipc_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect;

  assign redirect = br_taken && !halt && (state_q == S_FETCH || state_q == S_VALID);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (!br_taken) begin
          if (wait_q == 4'd0) begin
            instr_d = imem_instr;
            ipc_d   = pc_q;
            state_d = S_VALID;
          end else begin
            wait_d = wait_q - 4'd1;
          end
        end
      end
      S_VALID: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (instr_ready) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          pc_d    = pc_q + STEP;
          wait_d  = WAIT_INIT;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_BAD:   state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    // A redirect overrides the sequential pc but keeps any handshake counted above.
    if (redirect) begin
      pc_d    = {br_target[31:2], 2'b00};
      wait_d  = WAIT_INIT;
      state_d = S_FETCH;
      mis_d   = mis_q | (br_target[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      wait_q  <= WAIT_INIT;
      instr_q <= 32'd0;
      ipc_q   <= 32'd0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = (state_q == S_VALID);
  assign halted      = (state_q == S_HALT) || (state_q == S_BAD);
  assign misalign    = mis_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle-level reference model plus directed scenarios.
module tb_instr_fetch_unit;
  localparam int RD_WAIT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_instr, instr_out, instr_pc, br_target;
  logic        instr_valid, instr_ready, br_taken, halt, halted, misalign;
  logic [15:0] fetch_count;

  logic        w_rst_n = 1'b0;
  logic [31:0] w_addr, w_instr, w_out, w_pc;
  logic        w_valid, w_halted, w_mis;
  logic [3:0]  w_count;

  assign imem_instr = imem_addr + 32'h100;
  assign w_instr    = w_addr + 32'h100;

  instr_fetch_unit #(.RESET_PC(32'd0), .PC_STEP(4), .RD_WAIT(RD_WAIT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .br_taken(br_taken), .br_target(br_target),
    .halt(halt), .halted(halted), .misalign(misalign), .fetch_count(fetch_count));

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4), .RD_WAIT(RD_WAIT), .CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .imem_addr(w_addr), .imem_instr(w_instr),
    .instr_out(w_out), .instr_pc(w_pc), .instr_valid(w_valid),
    .instr_ready(1'b1), .br_taken(1'b0), .br_target(32'd0),
    .halt(1'b0), .halted(w_halted), .misalign(w_mis), .fetch_count(w_count));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch is "presented" once its address has been held RD_WAIT edges.
  logic [31:0] m_pc = 32'd0, m_last_pc = 32'd0, m_last_out = 32'd0;
  int          m_age = 0;
  int          m_count = 0;
  bit          m_halted = 1'b0, m_mis = 1'b0;

  always @(negedge clk) begin
    bit v;
    bit acc;
    if (!rst_n) begin
      m_pc = 32'd0; m_last_pc = 32'd0; m_last_out = 32'd0;
      m_age = 0; m_count = 0; m_halted = 1'b0; m_mis = 1'b0;
    end
    v = !m_halted && (m_age >= RD_WAIT);
    chk("m_addr",  imem_addr, m_pc);
    chk("m_valid", 32'(instr_valid), 32'(v));
    chk("m_halted", 32'(halted), 32'(m_halted));
    chk("m_misalign", 32'(misalign), 32'(m_mis));
    chk("m_count", 32'(fetch_count), 32'(m_count));
    chk("m_instr_pc", instr_pc, m_last_pc);
    chk("m_instr_out", instr_out, m_last_out);
    if (rst_n && !m_halted) begin
      if (halt) begin
        m_halted = 1'b1;
      end else begin
        acc = v && instr_ready;
        if (acc && m_count < 65535) m_count++;
        if (br_taken) begin
          m_pc  = br_target & 32'hFFFF_FFFC;
          m_age = 0;
          if (br_target[1:0] != 2'b00) m_mis = 1'b1;
        end else if (acc) begin
          m_pc  = m_pc + 32'd4;
          m_age = 0;
        end else begin
          m_age++;
          if (m_age == RD_WAIT) begin
            m_last_pc  = m_pc;
            m_last_out = m_pc + 32'h100;
          end
        end
      end
    end
  end

  logic [31:0] acc_pc[$];
  logic [31:0] acc_out[$];
  logic [31:0] w_q[$];

  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      acc_pc.push_back(instr_pc);
      acc_out.push_back(instr_out);
    end
    if (w_rst_n && w_valid) w_q.push_back(w_pc);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      checks++;
      failures++;
      $display("FAIL %s: instr_valid never rose within 20 cycles", name);
    end
  endtask

  initial begin
    instr_ready = 1'b1; br_taken = 1'b0; br_target = 32'd0; halt = 1'b0;
    repeat (3) step();
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    rst_n = 1'b1;
    w_rst_n = 1'b1;

    // Streaming with ready tied high: one accept every RD_WAIT+1 cycles.
    repeat (12) step();
    chk("seq_count", 32'(fetch_count), 32'd4);
    chk("seq_n", 32'(acc_pc.size()), 32'd4);
    if (acc_pc.size() >= 4) begin
      chk("seq_pc0", acc_pc[0], 32'd0);
      chk("seq_pc1", acc_pc[1], 32'd4);
      chk("seq_pc2", acc_pc[2], 32'd8);
      chk("seq_pc3", acc_pc[3], 32'd12);
      chk("seq_out3", acc_out[3], 32'h10C);
    end

    // Backpressure holds the presented word.
    instr_ready = 1'b0;
    wait_valid("bp_wait");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_pc", instr_pc, 32'd16);
      chk("bp_out", instr_out, 32'h110);
      chk("bp_addr", imem_addr, 32'd16);
      chk("bp_count", 32'(fetch_count), 32'd4);
    end
    instr_ready = 1'b1;
    step();
    chk("bp_done_count", 32'(fetch_count), 32'd5);

    // Redirect while fetching pc=20.
    instr_ready = 1'b0; br_taken = 1'b1; br_target = 32'd40;
    step();
    br_taken = 1'b0;
    wait_valid("brf_wait");
    chk("brf_pc", instr_pc, 32'd40);
    chk("brf_count", 32'(fetch_count), 32'd5);

    // Redirect together with an accept: counted, but pc takes the target.
    step();
    instr_ready = 1'b1; br_taken = 1'b1; br_target = 32'd8;
    step();
    instr_ready = 1'b0; br_taken = 1'b0;
    wait_valid("brv_wait");
    chk("brv_pc", instr_pc, 32'd8);
    chk("brv_count", 32'(fetch_count), 32'd6);

    // Misaligned target is truncated and flagged stickily.
    step();
    br_taken = 1'b1; br_target = 32'h2E;
    step();
    br_taken = 1'b0;
    wait_valid("mis_wait");
    chk("mis_pc", instr_pc, 32'h2C);
    chk("mis_flag", 32'(misalign), 32'd1);
    step();
    br_taken = 1'b1; br_target = 32'h100;
    step();
    br_taken = 1'b0;
    wait_valid("mis2_wait");
    chk("mis2_pc", instr_pc, 32'h100);
    chk("mis2_flag", 32'(misalign), 32'd1);

    // Halt beats redirect and accept in the same cycle.
    step();
    halt = 1'b1; br_taken = 1'b1; br_target = 32'h80; instr_ready = 1'b1;
    step();
    halt = 1'b0; br_taken = 1'b0;
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_addr", imem_addr, 32'h100);
    chk("halt_count", 32'(fetch_count), 32'd6);
    br_taken = 1'b1; br_target = 32'h44;
    repeat (3) step();
    br_taken = 1'b0;
    chk("halt_br_addr", imem_addr, 32'h100);
    chk("halt_br_flag", 32'(halted), 32'd1);
    chk("halt_br_valid", 32'(instr_valid), 32'd0);

    // Reset leaves HALT immediately.
    rst_n = 1'b0;
    #1;
    chk("rst2_addr", imem_addr, 32'd0);
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_mis", 32'(misalign), 32'd0);
    step();
    instr_ready = 1'b0;
    rst_n = 1'b1;
    wait_valid("r2_wait");
    chk("r2_pc", instr_pc, 32'd0);
    step();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    wait_valid("r3_wait");
    chk("r3_pc", instr_pc, 32'd4);
    chk("r3_count", 32'(fetch_count), 32'd1);

    // Asynchronous reset mid-handshake, checked between clock edges.
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_count", 32'(fetch_count), 32'd0);
    chk("arst_pc", instr_pc, 32'd0);
    step();
    rst_n = 1'b1;
    halt = 1'b1;
    step();
    halt = 1'b0; br_taken = 1'b1; br_target = 32'h13;
    repeat (3) step();
    br_taken = 1'b0;
    chk("hbr_mis", 32'(misalign), 32'd0);
    chk("hbr_halted", 32'(halted), 32'd1);
    chk("hbr_addr", imem_addr, 32'd0);

    // PC wrap and 4-bit saturating count on the second instance.
    repeat (10) step();
    chk("wrap_n_ok", 32'(w_q.size() >= 20), 32'd1);
    if (w_q.size() >= 2) begin
      chk("wrap_pc0", w_q[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", w_q[1], 32'd0);
    end
    chk("wrap_sat", 32'(w_count), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: owns the program counter, drives the fetch address and samples the returned instruction word after a fixed read-settle time.
- Presents each fetched instruction to decode with a valid/ready handshake.
- Accepts branch redirects and halt from execute.
- Sits between the asynchronous-read instruction memory and the decode stage of the processor.

Parameters:
- RESET_PC, 32'd0, fetch address after reset.
- PC_STEP, 4, byte increment between sequential instructions.
- RD_WAIT, 2, cycles the address is held stable before imem_instr is sampled; legal range 1..15.
- CNT_W, 16, width of the saturating fetch counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- imem_addr  output  32  address to instruction memory.
- imem_instr  input  32  instruction word from memory, valid RD_WAIT cycles after imem_addr changes.
- instr_out  output  32  latched instruction to decode.
- instr_pc  output  32  address instr_out was fetched from.
- instr_valid  output  1  instr_out/instr_pc valid.
- instr_ready  input  1  decode accepts instr_out this cycle.
- br_taken  input  1  redirect request, one-cycle pulse.
- br_target  input  32  redirect address, sampled when br_taken=1.
- halt  input  1  stop fetching (sticky until reset).
- halted  output  1  unit is in HALT.
- misalign  output  1  sticky: a br_target with nonzero bits [1:0] was received.
- fetch_count  output  CNT_W  number of accepted instructions, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, imem_addr=RESET_PC, state=FETCH, wait counter=RD_WAIT-1, instr_out=0, instr_pc=0, instr_valid=0, halted=0, misalign=0, fetch_count=0. All outputs hold these values while rst_n=0. Reset asserted mid-fetch or mid-handshake discards everything.
- imem_addr is always the registered pc, never combinational from inputs.
- FETCH state:
  - instr_valid=0.
  - Counter decrements each cycle.
  - On the cycle the counter is 0: instr_out<=imem_instr, instr_pc<=pc, state<=VALID.
  - First instruction after reset is therefore valid at rising edge RD_WAIT after reset release.
- VALID state:
  - instr_valid=1; instr_out/instr_pc are stable until the handshake completes.
  - On instr_ready=1: fetch_count+1 (saturate at all-ones), pc<=pc+PC_STEP (mod 2^32, wrap FFFFFFFC->0), counter<=RD_WAIT-1, state<=FETCH.
  - instr_valid is low in the following cycle. Throughput is one instruction per RD_WAIT+1 cycles.
- Redirect:
  - br_taken=1 in FETCH or VALID: pc<={br_target[31:2],2'b00}, counter<=RD_WAIT-1, state<=FETCH, instr_valid<=0.
  - Any in-flight or presented instruction is discarded and not counted.
  - If br_target[1:0]!=0, misalign<=1 (sticky until reset).
- Simultaneous events:
  - br_taken with instr_ready in VALID: the handshake completes (counted) and pc takes the target, not pc+PC_STEP.
  - halt has priority over br_taken and instr_ready.
  - halt=1 in any state: state<=HALT, instr_valid<=0, halted<=1. An instruction presented in that same cycle is not counted.
- HALT state: pc, imem_addr, instr_out, instr_pc and fetch_count are frozen. br_taken and instr_ready are ignored. Exit only by reset.
- br_taken in HALT has no effect, including on misalign.
- States are encoded in 2 bits; the unused encoding transitions to HALT with halted=1.

Test Plan:
- Reset release, RD_WAIT=2, memory returns word = addr+32'h100, instr_ready tied 1 -> instr_pc sequence 0,4,8,12 with instr_out 100,104,108,10C; valid every 3rd cycle; fetch_count=4 after 4 accepts.
- Backpressure: instr_ready=0 for 5 cycles at pc=8 -> instr_valid held 1, instr_out=108 and instr_pc=8 stable, imem_addr=8, fetch_count unchanged; ready=1 -> next instr_pc=12.
- Redirect in FETCH at pc=12 with br_target=40 -> no instr at 12 delivered, next instr_pc=40, fetch_count unchanged. Redirect in VALID with ready=1 at pc=28, target=8 -> count +1, next instr_pc=8.
- br_target=32'h2E -> fetch address 2C, misalign=1 and remains 1 after later aligned branches.
- halt asserted at pc=20 together with br_taken=1 and instr_ready=1 -> halted=1, instr_valid=0, imem_addr stays 20, fetch_count unchanged; br_taken afterwards has no effect; rst_n low restores pc=0 and halted=0.
- Wrap and saturate: RESET_PC=32'hFFFFFFFC -> second instr_pc=0. CNT_W=4 with 20 accepts -> fetch_count=15. Reset pulsed mid-FETCH -> instr_valid=0 immediately, not waiting for clk.
